perspective_divide: RTL and testbench

- Stage directly downstream of the 4x4 matrix-vector multiplier in the vertex pipeline.
- Takes one clip-space vertex (x, y, z, w), all Q16.16, and computes NDC x/w, y/w, z/w with one shared sequential restoring divider.
- Maps NDC x/y to integer pixel coordinates and passes NDC z through for the depth buffer.
- Vertices with w below a near threshold are flagged as clipped and are not divided.

---
 rtl/gfx_pkg.sv | 22 ++
 rtl/fixed_point_divider.sv | 89 ++++++++
 rtl/perspective_divide.sv | 204 ++++++++++++++++++++
 tb/tb_perspective_divide.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared vertex-pipeline types and constants: Q16.16 fixed-point words,
// the 4-component clip-space vector and the perspective-divide state encoding.
package gfx_pkg;
    localparam int GFX_WIDTH = 32;
    localparam int GFX_FRAC  = 16;
    localparam int GFX_H_RES = 320;
    localparam int GFX_V_RES = 240;

    localparam logic [GFX_WIDTH-1:0] FIXED_ONE  = 32'h0001_0000;
    localparam logic [GFX_WIDTH-1:0] GFX_NEAR_W = 32'h0000_1000;

    typedef logic signed [GFX_WIDTH-1:0] fixed_t;
    typedef logic [3:0][GFX_WIDTH-1:0]   vec4_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_DIVIDE   = 3'd2,
        ST_VIEWPORT = 3'd3,
        ST_DONE     = 3'd4
    } pd_state_e;
endpackage

// File: rtl/fixed_point_divider.sv
// Unsigned restoring divider, one quotient bit per clock. The start cycle
// already performs the first iteration, so valid rises DW cycles after start.
module fixed_point_divider #(
    parameter int DW = 48,
    parameter int VW = 32
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] quotient,
    output logic          overflow,
    output logic          valid
);
    localparam int CW = $clog2(DW) + 1;

    logic [VW-1:0] rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] dsr_q, dsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic          valid_q, valid_d;

    // Shift the next dividend bit into the remainder and subtract if it fits.
    function automatic logic [VW+DW-1:0] div_step(input logic [VW-1:0] rem,
                                                  input logic [DW-1:0] quo,
                                                  input logic [VW-1:0] dsr);
        logic [VW:0] trial;
        logic [VW:0] diff;
        trial = {rem, quo[DW-1]};
        diff  = trial - {1'b0, dsr};
        if (trial >= {1'b0, dsr}) begin
            div_step = {diff[VW-1:0], quo[DW-2:0], 1'b1};
        end else begin
            div_step = {trial[VW-1:0], quo[DW-2:0], 1'b0};
        end
    endfunction

    // Iteration control: load-and-step on start, then step until DW bits are done.
    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        valid_d  = 1'b0;
        if (start) begin
            {rem_d, quo_d} = div_step({VW{1'b0}}, dividend, divisor);
            dsr_d    = divisor;
            cnt_d    = CW'(32'd1);
            active_d = 1'b1;
        end else if (active_q) begin
            {rem_d, quo_d} = div_step(rem_q, quo_q, dsr_q);
            cnt_d = cnt_q + CW'(32'd1);
            if (cnt_q == CW'(DW - 1)) begin
                active_d = 1'b0;
                valid_d  = 1'b1;
            end else begin
                active_d = 1'b1;
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // Divider state registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rem_q    <= {VW{1'b0}};
            quo_q    <= {DW{1'b0}};
            dsr_q    <= {VW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            active_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            valid_q  <= valid_d;
        end
    end

    assign quotient = quo_q[VW-1:0];
    assign overflow = |quo_q[DW-1:VW-1];
    assign valid    = valid_q;
endmodule

// File: rtl/perspective_divide.sv
// Clip-space to screen-space stage: divides x, y, z by w with one shared
// divider, maps NDC x/y to pixels and passes NDC z through for depth.
module perspective_divide
    import gfx_pkg::*;
#(
    parameter int              WIDTH  = GFX_WIDTH,
    parameter int              FRAC   = GFX_FRAC,
    parameter int              H_RES  = GFX_H_RES,
    parameter int              V_RES  = GFX_V_RES,
    parameter logic [WIDTH-1:0] NEAR_W = GFX_NEAR_W
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           start,
    input  logic signed [3:0][WIDTH-1:0]   v_in,
    output logic signed [15:0]             x_pix,
    output logic signed [15:0]             y_pix,
    output logic signed [WIDTH-1:0]        z_ndc,
    output logic                           clipped,
    output logic                           busy,
    output logic                           done
);
    localparam int DW = WIDTH + FRAC;
    localparam int PW = WIDTH + 16;
    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] ONE_P  = {{(PW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [PW-1:0] HALF_H = PW'(H_RES / 32'sd2);
    localparam logic signed [PW-1:0] HALF_V = PW'(V_RES / 32'sd2);

    pd_state_e                    state_q, state_d;
    logic signed [3:0][WIDTH-1:0] v_q, v_d;
    logic [1:0]                   k_q, k_d;
    logic signed [WIDTH-1:0]      ndc_x_q, ndc_x_d, ndc_y_q, ndc_y_d, ndc_z_q, ndc_z_d;
    logic signed [15:0]           x_pix_q, x_pix_d, y_pix_q, y_pix_d;
    logic signed [WIDTH-1:0]      z_ndc_q, z_ndc_d;
    logic                         clipped_q, clipped_d, busy_q, busy_d, done_q, done_d;

    logic                         div_start_s, div_ovf_s, div_valid_s;
    logic [1:0]                   div_idx_s;
    logic [DW-1:0]                div_dividend_s;
    logic [WIDTH-1:0]             div_quo_s;
    logic signed [WIDTH-1:0]      div_mag_s, div_res_s;
    logic signed [PW-1:0]         prod_x_s, prod_y_s;

    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] val);
        if (val[WIDTH-1]) begin
            abs_mag = -val;
        end else begin
            abs_mag = val;
        end
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [PW-1:0] val);
        if (val > PW'(32'sd32767)) begin
            sat16 = 16'sh7FFF;
        end else if (val < PW'(-32'sd32768)) begin
            sat16 = 16'sh8000;
        end else begin
            sat16 = val[15:0];
        end
    endfunction

    fixed_point_divider #(
        .DW (DW),
        .VW (WIDTH)
    ) u_div (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start    (div_start_s),
        .dividend (div_dividend_s),
        .divisor  (v_q[3]),
        .quotient (div_quo_s),
        .overflow (div_ovf_s),
        .valid    (div_valid_s)
    );

    // Quotient sign/saturation and the viewport products, from current registers.
    always_comb begin
        div_mag_s = div_ovf_s ? MAX_POS : $signed(div_quo_s);
        if (v_q[k_q][WIDTH-1]) begin
            div_res_s = -div_mag_s;
        end else begin
            div_res_s = div_mag_s;
        end
        prod_x_s = ((PW'(ndc_x_q) + ONE_P) * HALF_H) >>> FRAC;
        prod_y_s = ((ONE_P - PW'(ndc_y_q)) * HALF_V) >>> FRAC;
        div_dividend_s = {abs_mag(v_q[div_idx_s]), {FRAC{1'b0}}};
    end

    // Control FSM next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        k_d         = k_q;
        ndc_x_d     = ndc_x_q;
        ndc_y_d     = ndc_y_q;
        ndc_z_d     = ndc_z_q;
        x_pix_d     = x_pix_q;
        y_pix_d     = y_pix_q;
        z_ndc_d     = z_ndc_q;
        clipped_d   = clipped_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_start_s = 1'b0;
        div_idx_s   = k_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    v_d     = v_in;
                    busy_d  = 1'b1;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // Signed compare also rejects w <= 0, so the divisor is always positive.
                if ($signed(v_q[3]) < $signed(NEAR_W)) begin
                    clipped_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    clipped_d   = 1'b0;
                    k_d         = 2'd0;
                    div_idx_s   = 2'd0;
                    div_start_s = 1'b1;
                    state_d     = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (div_valid_s) begin
                    case (k_q)
                        2'd0:    ndc_x_d = div_res_s;
                        2'd1:    ndc_y_d = div_res_s;
                        default: ndc_z_d = div_res_s;
                    endcase
                    if (k_q == 2'd2) begin
                        state_d = ST_VIEWPORT;
                    end else begin
                        // Next component is loaded in the same cycle to keep the divider busy.
                        k_d         = k_q + 2'd1;
                        div_idx_s   = k_q + 2'd1;
                        div_start_s = 1'b1;
                    end
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_VIEWPORT: begin
                x_pix_d = sat16(prod_x_s);
                y_pix_d = sat16(prod_y_s);
                z_ndc_d = ndc_z_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins in every state.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            v_q       <= '0;
            k_q       <= 2'd0;
            ndc_x_q   <= {WIDTH{1'b0}};
            ndc_y_q   <= {WIDTH{1'b0}};
            ndc_z_q   <= {WIDTH{1'b0}};
            x_pix_q   <= 16'sd0;
            y_pix_q   <= 16'sd0;
            z_ndc_q   <= {WIDTH{1'b0}};
            clipped_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            k_q       <= k_d;
            ndc_x_q   <= ndc_x_d;
            ndc_y_q   <= ndc_y_d;
            ndc_z_q   <= ndc_z_d;
            x_pix_q   <= x_pix_d;
            y_pix_q   <= y_pix_d;
            z_ndc_q   <= z_ndc_d;
            clipped_q <= clipped_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x_pix   = x_pix_q;
    assign y_pix   = y_pix_q;
    assign z_ndc   = z_ndc_q;
    assign clipped = clipped_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_perspective_divide.sv
// Bench for perspective_divide: directed vector table, control corner cases
// and randomized vertices checked against an arithmetic reference model.
module tb_perspective_divide;
    import gfx_pkg::*;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               start;
    vec4_t              v_in;
    logic signed [15:0] x_pix, y_pix;
    logic signed [31:0] z_ndc;
    logic               clipped, busy, done;

    int checks = 0;
    int errors = 0;

    int          r_dcyc, r_dcnt, r_bcnt;
    logic [15:0] r_x, r_y;
    logic [31:0] r_z;
    logic        r_clip;

    longint m_x = 0, m_y = 0, m_z = 0;
    logic   m_clip = 1'b0;

    typedef struct {
        logic [31:0] x, y, z, w;
        logic [15:0] ex, ey;
        logic [31:0] ez;
        logic        eclip;
    } vec_rec_t;

    perspective_divide dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .start   (start),
        .v_in    (v_in),
        .x_pix   (x_pix),
        .y_pix   (y_pix),
        .z_ndc   (z_ndc),
        .clipped (clipped),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic longint m_div(input longint v, input longint w);
        longint mag, q;
        mag = (v < 0) ? -v : v;
        q = (mag * 65536) / w;
        if (q > 64'sd2147483647) q = 64'sd2147483647;
        return (v < 0) ? -q : q;
    endfunction

    function automatic longint m_sat16(input longint p);
        if (p > 64'sd32767) return 64'sd32767;
        if (p < -64'sd32768) return -64'sd32768;
        return p;
    endfunction

    // Reference: divide, floor into the viewport, keep old outputs when clipped.
    task automatic model_op(input logic [31:0] vx, vy, vz, vw);
        longint w, nx, ny;
        w = longint'($signed(vw));
        if (w < 64'sd4096) begin
            m_clip = 1'b1;
        end else begin
            nx = m_div(longint'($signed(vx)), w);
            ny = m_div(longint'($signed(vy)), w);
            m_z = m_div(longint'($signed(vz)), w);
            m_x = m_sat16(((nx + 64'sd65536) * 64'sd160) >>> 16);
            m_y = m_sat16(((64'sd65536 - ny) * 64'sd120) >>> 16);
            m_clip = 1'b0;
        end
    endtask

    task automatic run_op(input logic [31:0] vx, vy, vz, vw, input int poke);
        @(negedge clk_in);
        v_in  = {vw, vz, vy, vx};
        start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        v_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
        r_dcyc = -1;
        r_dcnt = 0;
        r_bcnt = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc == poke + 1) start = 1'b0;
            if (cyc == poke) begin
                start = 1'b1;
                v_in  = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
            end
            if (busy === 1'b1) r_bcnt++;
            if (done === 1'b1) begin
                r_dcnt++;
                if (r_dcyc < 0) begin
                    r_dcyc = cyc;
                    r_x = x_pix;
                    r_y = y_pix;
                    r_z = z_ndc;
                    r_clip = clipped;
                end
            end
            if (r_dcyc >= 0 && cyc >= r_dcyc + 3) break;
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check_timing(input string tag, input logic clip);
        check({tag, "_latency"}, 64'(r_dcyc), clip ? 64'd2 : 64'd147);
        check({tag, "_busy_cycles"}, 64'(r_bcnt), clip ? 64'd1 : 64'd146);
        check({tag, "_done_pulses"}, 64'(r_dcnt), 64'd1);
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] ex, ey,
                                 input logic [31:0] ez, input logic eclip);
        check({tag, "_x_pix"}, 64'(r_x), 64'(ex));
        check({tag, "_y_pix"}, 64'(r_y), 64'(ey));
        check({tag, "_z_ndc"}, 64'(r_z), 64'(ez));
        check({tag, "_clipped"}, 64'(r_clip), 64'(eclip));
    endtask

    vec_rec_t tbl[8];

    initial begin
        // 1/3 gives ndc_y = -0x5555; (1 + 0.33332) * 120 = 159.99 floors to 159.
        tbl[0] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0003_0000, 16'd213, 16'd159, 32'h0000_0000, 1'b0};
        tbl[1] = '{32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000, 16'd320, 16'd180, 32'h0000_4000, 1'b0};
        tbl[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 16'd320, 16'd180, 32'h0000_4000, 1'b1};
        tbl[3] = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFE_0000, 16'd320, 16'd180, 32'h0000_4000, 1'b1};
        tbl[4] = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0FFF, 16'd320, 16'd180, 32'h0000_4000, 1'b1};
        tbl[5] = '{32'hFFFC_0000, 32'h0004_0000, 32'h0000_0000, 32'h0004_0000, 16'd0, 16'd0, 32'h0000_0000, 1'b0};
        tbl[6] = '{32'h7FFF_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_1000, 16'h7FFF, 16'd120, 32'h0000_0000, 1'b0};
        tbl[7] = '{32'h0000_0000, 32'h0000_0000, 32'h8001_0000, 32'h0000_1000, 16'd160, 16'd120, 32'h8000_0001, 1'b0};

        rst_in = 1'b0;
        start  = 1'b0;
        v_in   = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_x_pix", 64'(x_pix), 64'd0);
        check("reset_y_pix", 64'(y_pix), 64'd0);
        check("reset_z_ndc", 64'(z_ndc), 64'd0);
        check("reset_clipped", 64'(clipped), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].w, 0);
            model_op(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].w);
            check_timing($sformatf("vec%0d", i), tbl[i].eclip);
            check_outputs($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ez, tbl[i].eclip);
        end

        // A start pulse in the middle of an operation must be dropped, not queued.
        run_op(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000, 60);
        model_op(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000);
        check_timing("poke", 1'b0);
        check_outputs("poke", 16'd320, 16'd180, 32'h0000_4000, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] rx, ry, rz, rw;
            rx = 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
            ry = 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
            rz = 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
            case ($urandom_range(0, 3))
                0:       rw = 32'($urandom_range(0, 32'h0000_2000));
                1:       rw = 32'hFFFF_0000 - 32'($urandom_range(0, 32'h0004_0000));
                default: rw = 32'($urandom_range(32'h0000_8000, 32'h0008_0000));
            endcase
            run_op(rx, ry, rz, rw, 0);
            model_op(rx, ry, rz, rw);
            check_timing($sformatf("rand%0d", i), m_clip);
            check_outputs($sformatf("rand%0d", i), 16'(m_x), 16'(m_y), 32'(m_z), m_clip);
        end

        // Reset in the middle of a division clears everything on the next cycle.
        run_op(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000, 0);
        @(negedge clk_in);
        v_in  = {32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000, 32'h0002_0000};
        start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        repeat (79) @(posedge clk_in);
        #1;
        check("midop_busy", 64'(busy), 64'd1);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_x_pix", 64'(x_pix), 64'd0);
        check("rst_y_pix", 64'(y_pix), 64'd0);
        check("rst_z_ndc", 64'(z_ndc), 64'd0);
        check("rst_clipped", 64'(clipped), 64'd0);
        rst_in = 1'b1;
        m_x = 0;
        m_y = 0;
        m_z = 0;
        m_clip = 1'b0;

        run_op(32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0003_0000, 0);
        model_op(32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0003_0000);
        check_timing("after_rst", 1'b0);
        check_outputs("after_rst", 16'(m_x), 16'(m_y), 32'(m_z), m_clip);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
